// File: rtl/system_pio_irq_servicer.sv
// Avalon-MM initiator that arms an edge-capture PIO's irq mask, then services
// each irq: read capture, clear it, sample the input level, report the event.
module system_pio_irq_servicer #(
  parameter logic [31:0] MASK_INIT    = 32'h1,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq_in,
  output logic             event_pulse,
  output logic             last_level,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] spurious_count,
  output logic             busy
);

  localparam int unsigned LAT_W = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_IRQ, S_RD_CAP, S_CAP_WAIT,
    S_CLEAR, S_RD_LVL, S_LVL_WAIT, S_GUARD
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               spur_q, spur_d;
  logic               lat_done;
  logic               rd_bit0;

  logic [1:0]         addr_d;
  logic               cs_d, wn_d, pulse_d, level_d, busy_d;
  logic [31:0]        wdata_d;
  logic [CNT_W-1:0]   ev_cnt_d, sp_cnt_d;

  assign lat_done = (lat_q == LAT_W'(READ_LATENCY - 1));
  assign rd_bit0  = (m_readdata & 32'h1) != 32'h0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; enable is only honoured between services
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_INIT;
      S_INIT:     state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (!enable)     state_d = S_IDLE;
        else if (irq_in) state_d = S_RD_CAP;
      end
      S_RD_CAP:   state_d = S_CAP_WAIT;
      S_CAP_WAIT: if (lat_done) state_d = S_CLEAR;
      S_CLEAR:    state_d = S_RD_LVL;
      S_RD_LVL:   state_d = S_LVL_WAIT;
      S_LVL_WAIT: if (lat_done) state_d = S_GUARD;
      S_GUARD:    state_d = S_WAIT_IRQ;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: bus strobes follow the state being entered so they register
  // in step with it; address and write data hold through read waits.
  always_comb begin
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = m_address;
    wdata_d  = m_writedata;
    pulse_d  = 1'b0;
    level_d  = last_level;
    ev_cnt_d = event_count;
    sp_cnt_d = spurious_count;
    spur_d   = spur_q;
    lat_d    = '0;
    busy_d   = !((state_d == S_IDLE) || (state_d == S_WAIT_IRQ));

    case (state_d)
      S_INIT:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wdata_d = MASK_INIT; end
      S_RD_CAP: begin cs_d = 1'b1; addr_d = 2'd3; end
      S_CLEAR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd3; wdata_d = 32'h1; end
      S_RD_LVL: begin cs_d = 1'b1; addr_d = 2'd0; end
      default:  ;
    endcase

    if ((state_d == state_q) && ((state_q == S_CAP_WAIT) || (state_q == S_LVL_WAIT)))
      lat_d = lat_q + LAT_W'(1);

    if ((state_q == S_CAP_WAIT) && lat_done) begin
      spur_d = !rd_bit0;
      if (!rd_bit0) sp_cnt_d = spurious_count + CNT_W'(1);
    end

    if ((state_q == S_LVL_WAIT) && lat_done) begin
      level_d = rd_bit0;
      if (!spur_q) begin
        ev_cnt_d = event_count + CNT_W'(1);
        pulse_d  = 1'b1;
      end
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_chipselect   <= 1'b0;
      m_write_n      <= 1'b1;
      m_address      <= 2'd0;
      m_writedata    <= 32'h0;
      event_pulse    <= 1'b0;
      last_level     <= 1'b0;
      event_count    <= '0;
      spurious_count <= '0;
      busy           <= 1'b0;
      spur_q         <= 1'b0;
      lat_q          <= '0;
    end else begin
      m_chipselect   <= cs_d;
      m_write_n      <= wn_d;
      m_address      <= addr_d;
      m_writedata    <= wdata_d;
      event_pulse    <= pulse_d;
      last_level     <= level_d;
      event_count    <= ev_cnt_d;
      spurious_count <= sp_cnt_d;
      busy           <= busy_d;
      spur_q         <= spur_d;
      lat_q          <= lat_d;
    end
  end

endmodule

// File: tb/tb_system_pio_irq_servicer.sv
// Directed bench: edge-capture PIO slave model with 3-cycle read latency,
// 4-bit counters so wrap-around is reachable.
module tb_system_pio_irq_servicer;

  localparam int unsigned RL = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    m_address;
  logic          m_chipselect;
  logic          m_write_n;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata;
  logic          irq_in;
  logic          event_pulse;
  logic          last_level;
  logic [CW-1:0] event_count;
  logic [CW-1:0] spurious_count;
  logic          busy;

  logic          in_port;
  logic          force_irq;

  int checks = 0;
  int errors = 0;

  system_pio_irq_servicer #(
    .MASK_INIT(32'h1), .READ_LATENCY(RL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq_in(irq_in),
    .event_pulse(event_pulse), .last_level(last_level),
    .event_count(event_count), .spurious_count(spurious_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave model: edge capture on bit 0, irq = capture & mask
  logic [31:0] s_cap, s_mask, rd_val;
  logic        s_prev, s_edge;
  logic [31:0] rd_pipe [RL];

  assign s_edge     = in_port & ~s_prev;
  assign irq_in     = (|(s_cap & s_mask)) | force_irq;
  assign m_readdata = rd_pipe[RL-1];

  always_comb begin
    case (m_address)
      2'd0:    rd_val = {31'b0, in_port};
      2'd2:    rd_val = s_mask;
      2'd3:    rd_val = s_cap;
      default: rd_val = 32'h0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_cap  <= 32'h0;
      s_mask <= 32'h0;
      s_prev <= 1'b0;
      for (int i = 0; i < RL; i++) rd_pipe[i] <= 32'h0;
    end else begin
      s_prev <= in_port;
      if (m_chipselect && !m_write_n && m_address == 2'd2) s_mask <= m_writedata;
      if (m_chipselect && !m_write_n && m_address == 2'd3)
        s_cap <= (s_cap & ~m_writedata) | {31'b0, s_edge};
      else
        s_cap <= s_cap | {31'b0, s_edge};
      rd_pipe[0] <= (m_chipselect && m_write_n) ? rd_val : 32'h0;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Bus monitor: access log, pulse count, busy run length, read-wait address hold
  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t acc_log[$];
  int   pulse_cnt = 0;
  int   run_cnt = 0;
  int   last_run = 0;
  int   hold_left = 0;
  int   hold_err = 0;
  logic [1:0] hold_addr = 2'd0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (m_chipselect)
        acc_log.push_back('{wr: !m_write_n, addr: m_address,
                            data: m_write_n ? 32'h0 : m_writedata});
      if (event_pulse) pulse_cnt <= pulse_cnt + 1;
      if (busy) run_cnt <= run_cnt + 1;
      else if (run_cnt != 0) begin
        last_run <= run_cnt;
        run_cnt  <= 0;
      end
      if (hold_left > 0) begin
        if (m_chipselect || m_address != hold_addr) hold_err <= hold_err + 1;
        hold_left <= hold_left - 1;
      end
      if (m_chipselect && m_write_n) begin
        hold_left <= RL;
        hold_addr <= m_address;
      end
    end else begin
      hold_left <= 0;
      run_cnt   <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic wr,
                         input logic [1:0] addr, input logic [31:0] data);
    acc_t a;
    a = (idx < acc_log.size()) ? acc_log[idx] : '1;
    chk(tag, 64'(a), 64'({wr, addr, data}));
  endtask

  // Expected service pattern: read cap, clear cap, read level
  task automatic chk_service(input string tag, input int base);
    chk_acc({tag, "_rdcap"}, base,     1'b0, 2'd3, 32'h0);
    chk_acc({tag, "_clear"}, base + 1, 1'b1, 2'd3, 32'h1);
    chk_acc({tag, "_rdlvl"}, base + 2, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic make_edge();
    in_port = 1'b0;
    tick(2);
    in_port = 1'b1;
    tick(20);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    in_port   = 1'b0;
    force_irq = 1'b0;
    tick(3);

    // Reset values
    chk("rst_cs",    64'(m_chipselect),   64'd0);
    chk("rst_wn",    64'(m_write_n),      64'd1);
    chk("rst_addr",  64'(m_address),      64'd0);
    chk("rst_wdata", 64'(m_writedata),    64'd0);
    chk("rst_pulse", 64'(event_pulse),    64'd0);
    chk("rst_level", 64'(last_level),     64'd0);
    chk("rst_ev",    64'(event_count),    64'd0);
    chk("rst_sp",    64'(spurious_count), 64'd0);
    chk("rst_busy",  64'(busy),           64'd0);
    reset_n = 1'b1;
    tick(2);

    // Init: single mask write
    enable = 1'b1;
    tick(6);
    chk("init_n",    64'(acc_log.size()), 64'd1);
    chk_acc("init_wr", 0, 1'b1, 2'd2, 32'h1);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_run",  64'(last_run), 64'd1);
    acc_log.delete();

    // First real edge
    make_edge();
    chk("ev1_n", 64'(acc_log.size()), 64'd3);
    chk_service("ev1", 0);
    chk("ev1_ev",    64'(event_count),    64'd1);
    chk("ev1_sp",    64'(spurious_count), 64'd0);
    chk("ev1_level", 64'(last_level),     64'd1);
    chk("ev1_pulse", 64'(pulse_cnt),      64'd1);
    chk("ev1_run",   64'(last_run),       64'd10);
    acc_log.delete();

    // Spurious irq: capture reads 0, clear still issued
    force_irq = 1'b1;
    tick(1);
    force_irq = 1'b0;
    tick(20);
    chk("sp_n", 64'(acc_log.size()), 64'd3);
    chk_service("sp", 0);
    chk("sp_sp",    64'(spurious_count), 64'd1);
    chk("sp_ev",    64'(event_count),    64'd1);
    chk("sp_pulse", 64'(pulse_cnt),      64'd1);
    acc_log.delete();

    // Ten spaced edges
    for (int k = 0; k < 10; k++) make_edge();
    chk("ten_n", 64'(acc_log.size()), 64'd30);
    for (int k = 0; k < 10; k++) chk_service($sformatf("ten%0d", k), 3 * k);
    chk("ten_ev",    64'(event_count), 64'd11);
    chk("ten_pulse", 64'(pulse_cnt),   64'd11);
    chk("ten_run",   64'(last_run),    64'd10);
    acc_log.delete();

    // Counter wrap from all-ones
    for (int k = 0; k < 4; k++) make_edge();
    chk("wrap_full", 64'(event_count), 64'hF);
    make_edge();
    chk("wrap_zero", 64'(event_count), 64'h0);
    chk("wrap_sp",   64'(spurious_count), 64'd1);
    acc_log.delete();

    // Enable dropped mid-service: sequence completes, then parks
    in_port = 1'b0;
    tick(2);
    in_port = 1'b1;
    tick(4);
    enable = 1'b0;
    tick(20);
    chk("drop_n",    64'(acc_log.size()), 64'd3);
    chk_service("drop", 0);
    chk("drop_ev",   64'(event_count), 64'd1);
    chk("drop_busy", 64'(busy),        64'd0);
    acc_log.delete();
    enable = 1'b1;
    tick(6);
    chk("reinit_n", 64'(acc_log.size()), 64'd1);
    chk_acc("reinit_wr", 0, 1'b1, 2'd2, 32'h1);
    acc_log.delete();

    // Reset asserted during CAP_WAIT
    in_port = 1'b0;
    tick(2);
    in_port = 1'b1;
    tick(4);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_cs",    64'(m_chipselect),   64'd0);
    chk("arst_wn",    64'(m_write_n),      64'd1);
    chk("arst_addr",  64'(m_address),      64'd0);
    chk("arst_wdata", 64'(m_writedata),    64'd0);
    chk("arst_level", 64'(last_level),     64'd0);
    chk("arst_ev",    64'(event_count),    64'd0);
    chk("arst_sp",    64'(spurious_count), 64'd0);
    chk("arst_busy",  64'(busy),           64'd0);
    in_port = 1'b0;
    tick(2);
    acc_log.delete();
    reset_n = 1'b1;
    tick(6);
    chk("rerst_n", 64'(acc_log.size()), 64'd1);
    chk_acc("rerst_wr", 0, 1'b1, 2'd2, 32'h1);
    chk("rerst_ev", 64'(event_count), 64'd0);

    chk("addr_hold", 64'(hold_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
